// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - line-based simulation main memory on the shared request/response bus.
// Optional MEM_RESP_CRITICAL_WORD_FIRST_EN: read beats start at the addressed word and wrap within the line.
module mem_bus_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int ADDRESS_WIDTH  = 64,
  parameter int MEM_WORDS      = 4096,
  parameter int LINE_BEATS     = 8,
  parameter int LATENCY        = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] in_bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  in_bus_reqtag,
  output logic                      out_bus_reqack,
  output logic                      out_bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] out_bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  out_bus_resptag,
  input  logic                      in_bus_respack,
  output logic                      out_busy
);

  localparam int BEAT_W   = $clog2(LINE_BEATS);
  localparam int IDX_W    = $clog2(MEM_WORDS);
  localparam int LINE_W   = IDX_W - BEAT_W;
  localparam int WORD_LSB = $clog2(BUS_DATA_WIDTH / 8);
  localparam int LINE_LSB = WORD_LSB + BEAT_W;
  localparam int WAIT_W   = $clog2(LATENCY + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);
  localparam logic [WAIT_W-1:0] WAIT_END  = WAIT_W'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WR_DATA, S_RD_WAIT, S_RD_RESP} state_t;

  state_t                    state_q, state_d;
  logic [LINE_W-1:0]         line_q, line_d;
  logic [BEAT_W-1:0]         off_q, off_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [WAIT_W-1:0]         wait_q, wait_d;
  logic                      reqack_q, reqack_d;
  logic                      respcyc_q, respcyc_d;
  logic [BUS_DATA_WIDTH-1:0] resp_q, resp_d;
  logic [BUS_TAG_WIDTH-1:0]  resptag_q, resptag_d;

  logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic                      mem_we;
  logic [IDX_W-1:0]          mem_waddr;
  logic                      accept;
  logic [BEAT_W-1:0]         beat_nxt;
  logic [BEAT_W-1:0]         rd_first;
  logic [BEAT_W-1:0]         rd_next;
  logic [BEAT_W-1:0]         req_off;

  // No beat is sampled while the previous ack pulse is still high.
  assign accept   = in_bus_reqcyc && !reqack_q &&
                    ((state_q == S_IDLE) || (state_q == S_WR_DATA));
  assign beat_nxt = beat_q + 1'b1;
  assign rd_first = off_q;
  assign rd_next  = off_q + beat_nxt;

`ifdef MEM_RESP_CRITICAL_WORD_FIRST_EN
  assign req_off = in_bus_req[WORD_LSB +: BEAT_W];
`else
  assign req_off = '0;
`endif

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    off_d     = off_q;
    beat_d    = beat_q;
    wait_d    = wait_q;
    reqack_d  = 1'b0;
    respcyc_d = respcyc_q;
    resp_d    = resp_q;
    resptag_d = resptag_q;
    mem_we    = 1'b0;
    mem_waddr = {line_q, beat_q};
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          reqack_d = 1'b1;
          line_d   = in_bus_req[LINE_LSB +: LINE_W];
          beat_d   = '0;
          wait_d   = '0;
          if (in_bus_reqtag[BUS_TAG_WIDTH-1]) begin
            off_d   = '0;
            state_d = S_WR_DATA;
          end else begin
            off_d     = req_off;
            resptag_d = in_bus_reqtag;
            state_d   = S_RD_WAIT;
          end
        end
      end
      S_WR_DATA: begin
        if (accept) begin
          reqack_d = 1'b1;
          mem_we   = 1'b1;
          beat_d   = beat_nxt;
          if (beat_q == LAST_BEAT) state_d = S_IDLE;
        end
      end
      S_RD_WAIT: begin
        if (wait_q == WAIT_END) begin
          state_d   = S_RD_RESP;
          respcyc_d = 1'b1;
          resp_d    = mem[{line_q, rd_first}];
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_RD_RESP: begin
        if (in_bus_respack) begin
          if (beat_q == LAST_BEAT) begin
            respcyc_d = 1'b0;
            resp_d    = '0;
            beat_d    = '0;
            state_d   = S_IDLE;
          end else begin
            beat_d = beat_nxt;
            resp_d = mem[{line_q, rd_next}];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      line_q    <= '0;
      off_q     <= '0;
      beat_q    <= '0;
      wait_q    <= '0;
      reqack_q  <= 1'b0;
      respcyc_q <= 1'b0;
      resp_q    <= '0;
      resptag_q <= '0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      off_q     <= off_d;
      beat_q    <= beat_d;
      wait_q    <= wait_d;
      reqack_q  <= reqack_d;
      respcyc_q <= respcyc_d;
      resp_q    <= resp_d;
      resptag_q <= resptag_d;
    end
  end

  // Storage is deliberately left out of reset so contents survive a bus reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= in_bus_req;
  end

  assign out_bus_reqack  = reqack_q;
  assign out_bus_respcyc = respcyc_q;
  assign out_bus_resp    = resp_q;
  assign out_bus_resptag = resptag_q;
  assign out_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - randomized directed bench for mem_bus_responder against a line-array model.
module tb_mem_bus_responder;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_bus_reqcyc = 1'b0;
  logic [63:0] in_bus_req = '0;
  logic [12:0] in_bus_reqtag = '0;
  logic        out_bus_reqack;
  logic        out_bus_respcyc;
  logic [63:0] out_bus_resp;
  logic [12:0] out_bus_resptag;
  logic        in_bus_respack = 1'b0;
  logic        out_busy;

  int errors = 0;
  int checks = 0;
  logic [63:0] mem_m [0:4095];

  mem_bus_responder dut (
    .clk             (clk),
    .reset           (reset),
    .in_bus_reqcyc   (in_bus_reqcyc),
    .in_bus_req      (in_bus_req),
    .in_bus_reqtag   (in_bus_reqtag),
    .out_bus_reqack  (out_bus_reqack),
    .out_bus_respcyc (out_bus_respcyc),
    .out_bus_resp    (out_bus_resp),
    .out_bus_resptag (out_bus_resptag),
    .in_bus_respack  (in_bus_respack),
    .out_busy        (out_busy)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int line_base(input logic [63:0] addr);
    return int'((addr >> 6) & 64'h1FF) * 8;
  endfunction

  function automatic logic [63:0] model_beat(input logic [63:0] addr, input int k);
    int off;
`ifdef MEM_RESP_CRITICAL_WORD_FIRST_EN
    off = int'((addr >> 3) & 64'h7);
`else
    off = 0;
`endif
    return mem_m[line_base(addr) + ((off + k) % 8)];
  endfunction

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_bus_reqack && n < 40);
    check("ack_timeout", 64'(n < 40), 64'd1);
  endtask

  task automatic write_line(input logic [63:0] addr, input logic [63:0] data [8]);
    int n;
    in_bus_reqcyc = 1'b1;
    in_bus_req    = addr;
    in_bus_reqtag = 13'h1000 | 13'($urandom_range(0, 4095));
    wait_ack(n);
    check("wr_busy", 64'(out_busy), 64'd1);
    for (int k = 0; k < 8; k++) begin
      in_bus_req = data[k];
      wait_ack(n);
      check("wr_ack_spacing", 64'(n), 64'd2);
    end
    check("wr_done_idle", 64'(out_busy), 64'd0);
    in_bus_reqcyc = 1'b0;
    in_bus_req    = '0;
    for (int k = 0; k < 8; k++) mem_m[line_base(addr) + k] = data[k];
  endtask

  task automatic read_line(input logic [63:0] addr, input logic [12:0] tag,
                           input int stall_beat, input int stall_len,
                           input bit queue_next, input logic [63:0] next_addr,
                           input logic [12:0] next_tag, input int abort_beat,
                           input int exp_ack_n);
    int n;
    int st;
    logic [63:0] exp;
    in_bus_reqcyc = 1'b1;
    in_bus_req    = addr;
    in_bus_reqtag = tag;
    wait_ack(n);
    if (exp_ack_n >= 0) check("rd_ack_delay", 64'(n), 64'(exp_ack_n));
    in_bus_reqcyc = 1'b0;
    check("rd_busy", 64'(out_busy), 64'd1);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_bus_respcyc && n < 40);
    check("rd_latency", 64'(n), 64'(LAT));
    for (int k = 0; k < 8; k++) begin
      if (queue_next && k == 1) begin
        in_bus_reqcyc = 1'b1;
        in_bus_req    = next_addr;
        in_bus_reqtag = next_tag;
      end
      exp = model_beat(addr, k);
      check("rd_data", out_bus_resp, exp);
      check("rd_tag", 64'(out_bus_resptag), 64'(tag));
      if (k == abort_beat) begin
        #2 reset = 1'b0;
        #1;
        check("rst_respcyc", 64'(out_bus_respcyc), 64'd0);
        check("rst_reqack", 64'(out_bus_reqack), 64'd0);
        check("rst_busy", 64'(out_busy), 64'd0);
        check("rst_resp", out_bus_resp, 64'd0);
        @(negedge clk) reset = 1'b1;
        return;
      end
      st = (k == stall_beat) ? stall_len : int'($urandom_range(0, 2));
      in_bus_respack = 1'b0;
      repeat (st) begin
        @(posedge clk); #1;
        check("rd_stall_data", out_bus_resp, exp);
        check("rd_stall_cyc", 64'(out_bus_respcyc), 64'd1);
        if (queue_next) check("q_no_ack", 64'(out_bus_reqack), 64'd0);
      end
      in_bus_respack = 1'b1;
      @(posedge clk); #1;
      in_bus_respack = 1'b0;
      if (queue_next) check("q_no_ack", 64'(out_bus_reqack), 64'd0);
    end
    check("rd_end_cyc", 64'(out_bus_respcyc), 64'd0);
    check("rd_end_resp", out_bus_resp, 64'd0);
    check("rd_end_busy", 64'(out_busy), 64'd0);
    check("rd_end_tag", 64'(out_bus_resptag), 64'(tag));
  endtask

  initial begin
    logic [63:0] d [8];
    logic [63:0] a;
    logic [63:0] ra;
    logic [12:0] t;
    logic [12:0] t2;

    repeat (3) @(posedge clk);
    #1;
    check("reset_reqack", 64'(out_bus_reqack), 64'd0);
    check("reset_respcyc", 64'(out_bus_respcyc), 64'd0);
    check("reset_resp", out_bus_resp, 64'd0);
    check("reset_resptag", 64'(out_bus_resptag), 64'd0);
    check("reset_busy", 64'(out_busy), 64'd0);
    @(negedge clk) reset = 1'b1;

    for (int k = 0; k < 8; k++) d[k] = 64'(8'h11 * (k + 1));
    write_line(64'h1000, d);
    t = 13'($urandom_range(0, 4095));
    read_line(64'h1000, t, -1, 0, 1'b0, '0, '0, -1, -1);
    t = 13'($urandom_range(0, 4095));
    read_line(64'h1018, t, -1, 0, 1'b0, '0, '0, -1, -1);

    for (int i = 0; i < 4; i++) begin
      a = {$urandom, $urandom};
      if (((a >> 6) & 64'h1FF) == 64'h40) a = a ^ 64'h40;
      for (int k = 0; k < 8; k++) d[k] = {$urandom, $urandom};
      write_line(a, d);
      ra = {$urandom, $urandom};
      ra = (ra & ~64'h7FC0) | (a & 64'h7FC0);
      t = 13'($urandom_range(0, 4095));
      read_line(ra, t, -1, 0, 1'b0, '0, '0, -1, -1);
    end

    t = 13'($urandom_range(0, 4095));
    read_line(64'h1000, t, 3, 5, 1'b0, '0, '0, -1, -1);

    t  = 13'($urandom_range(0, 4095));
    t2 = 13'($urandom_range(0, 4095));
    read_line(64'h1000, t, -1, 0, 1'b1, 64'h1008, t2, -1, -1);
    read_line(64'h1008, t2, -1, 0, 1'b0, '0, '0, -1, 1);

    t = 13'($urandom_range(0, 4095));
    read_line(64'h1000, t, -1, 0, 1'b0, '0, '0, 4, -1);
    t = 13'($urandom_range(0, 4095));
    read_line(64'h1000, t, -1, 0, 1'b0, '0, '0, -1, -1);

    for (int k = 0; k < 8; k++) d[k] = {$urandom, $urandom};
    write_line(64'hABCD_0000_0010_9000, d);
    t = 13'($urandom_range(0, 4095));
    read_line(64'h1030, t, -1, 0, 1'b0, '0, '0, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
